alu_rr_sequencer: RTL and testbench

//  Shares one ALU_8Bit instance between two requesters, using round-robin arbitration.
//  It registers the granted operands and runs one ALU operation per grant.
//  It returns the registered result on one shared response channel, tagged with the requester ID.
//  It sits between the client blocks and the combinational ALU, so the ALU needs no handshaking.

---
 rtl/alu_rr_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: two requesters share one combinational ALU_8Bit under round-robin arbitration.
// Optional per-requester response counters op_cnt0/op_cnt1 when ALU_RR_SEQUENCER_STATS_EN is defined.

module ALU_8Bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] mode,
  output logic [7:0] out
);
  always_comb begin
    out = '0;
    case (mode)
      4'h0: out = a + b;
      4'h1: out = a - b;
      4'h2: out = a & b;
      4'h3: out = a | b;
      4'h4: out = a ^ b;
      4'h5: out = ~a;
      4'h6: out = a << 1;
      4'h7: out = a >> 1;
      4'h8: out = {a[6:0], a[7]};
      4'h9: out = {a[0], a[7:1]};
      4'hA: out = a + 8'd1;
      4'hB: out = a - 8'd1;
      4'hC: out = ~(a & b);
      4'hD: out = ~(a | b);
      4'hE: out = ~(a ^ b);
      4'hF: out = (a > b) ? a : b;
    endcase
  end
endmodule

module alu_rr_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MODE_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [MODE_W-1:0] req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [MODE_W-1:0] req1_mode,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready
`ifdef ALU_RR_SEQUENCER_STATS_EN
  ,
  output logic [CNT_W-1:0]  op_cnt0,
  output logic [CNT_W-1:0]  op_cnt1
`endif
);

  if (DATA_W != 8 || MODE_W != 4 || CNT_W == 0) begin : g_param_check
    $error("alu_rr_sequencer: DATA_W must be 8, MODE_W must be 4, CNT_W must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;
  logic              grant0, grant1;
  logic [DATA_W-1:0] alu_out;

  ALU_8Bit u_alu (
    .a    (a_q),
    .b    (b_q),
    .mode (mode_q),
    .out  (alu_out)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    mode_d       = mode_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // On a tie the requester that did not win last time is served.
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    unique case (state_q)
      IDLE: begin
        // Ready is withheld under reset so no requester sees a phantom acceptance.
        req0_ready = grant0 & ~rst;
        req1_ready = grant1 & ~rst;
        if (req0_ready) begin
          a_d          = req0_a;
          b_d          = req0_b;
          mode_d       = req0_mode;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (req1_ready) begin
          a_d          = req1_a;
          b_d          = req1_b;
          mode_d       = req1_mode;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_out;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= '0;
      id_q         <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mode_q       <= mode_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_RR_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (rsp_valid && rsp_ready) begin
      if (!rsp_id_q && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
      if (rsp_id_q && cnt1_q != '1)  cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign op_cnt0 = cnt0_q;
  assign op_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: cycle-level behavioural model checked every cycle, plus directed literal checks.
module tb_alu_rr_sequencer;

`ifdef ALU_RR_SEQUENCER_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_mode, req1_mode;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [7:0] rsp_data;
`ifdef ALU_RR_SEQUENCER_STATS_EN
  logic [TB_CNT_W-1:0] op_cnt0, op_cnt1;
`endif

  alu_rr_sequencer #(.DATA_W(8), .MODE_W(4), .CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
`ifdef ALU_RR_SEQUENCER_STATS_EN
    ,
    .op_cnt0    (op_cnt0),
    .op_cnt1    (op_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit model_en = 0;
  int acc_cyc;

  int         log_id[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] alu_ref(input int a, input int b, input int m);
    int r;
    case (m)
      0:  r = a + b;
      1:  r = a - b + 256;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  r = a * 2;
      7:  r = a / 2;
      8:  r = a * 2 + a / 128;
      9:  r = a / 2 + (a % 2) * 128;
      10: r = a + 1;
      11: r = a + 255;
      12: r = 255 - (a & b);
      13: r = 255 - (a | b);
      14: r = 255 - (a ^ b);
      default: r = (a > b) ? a : b;
    endcase
    return 8'(r % 256);
  endfunction

  // Model: at most one operation in flight; visible two cycles after acceptance,
  // retired on consumer acceptance, and the block is free again the cycle after.
  bit         m_busy = 0;
  int         m_age  = 0;
  bit         m_last = 1;
  bit         m_id   = 0;
  logic [7:0] m_data = '0;
  int         m_cnt0 = 0, m_cnt1 = 0;

  initial begin
    bit e_r0, e_r1, e_v;
    wait (model_en);
    forever begin
      @(negedge clk);
      if (!m_busy) begin
        e_r0 = !rst && req0_valid && (!req1_valid || m_last);
        e_r1 = !rst && req1_valid && (!req0_valid || !m_last);
        e_v  = 0;
      end else begin
        e_r0 = 0;
        e_r1 = 0;
        e_v  = (m_age >= 2);
      end
      check("req0_ready", 32'(req0_ready), 32'(e_r0));
      check("req1_ready", 32'(req1_ready), 32'(e_r1));
      check("rsp_valid", 32'(rsp_valid), 32'(e_v));
      if (e_v) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_data", 32'(rsp_data), 32'(m_data));
      end
`ifdef ALU_RR_SEQUENCER_STATS_EN
      check("op_cnt0", 32'(op_cnt0), 32'(m_cnt0));
      check("op_cnt1", 32'(op_cnt1), 32'(m_cnt1));
`endif
      if (rsp_valid && rsp_ready) begin
        log_id.push_back(int'(rsp_id));
        log_data.push_back(rsp_data);
        log_cyc.push_back(cyc);
      end
      if (rst) begin
        m_busy = 0; m_age = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      end else if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_busy = 1;
          m_age  = 1;
          m_id   = e_r1;
          m_last = e_r1;
          m_data = e_r1 ? alu_ref(int'(req1_a), int'(req1_b), int'(req1_mode))
                        : alu_ref(int'(req0_a), int'(req0_b), int'(req0_mode));
        end
      end else if (e_v && rsp_ready) begin
        m_busy = 0;
        if (!m_id && m_cnt0 < CNT_MAX) m_cnt0++;
        if (m_id && m_cnt1 < CNT_MAX)  m_cnt1++;
      end else if (m_age < 2) begin
        m_age++;
      end
    end
  end

  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    bit ok = 0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_mode = m; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_mode = m; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    if (!ok) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 60 && log_id.size() < n; i++) begin
      @(posedge clk); #1;
    end
    check("rsp_count", 32'(log_id.size()), 32'(n));
  endtask

  logic [7:0] sweep_exp [16];
  logic [7:0] c0_a [3], c0_b [3], c1_a [3], c1_b [3];
  logic [3:0] c0_m [3], c1_m [3];
  logic [7:0] cont_exp [6];

  initial begin
    int base;
    bit got, h0, h1;
    int idx0, idx1;
    sweep_exp = '{8'h00, 8'hEC, 8'h02, 8'hFE, 8'hFC, 8'h09, 8'hEC, 8'h7B,
                  8'hED, 8'h7B, 8'hF7, 8'hF5, 8'hFD, 8'h01, 8'h03, 8'hF6};
    c0_a = '{8'h11, 8'h33, 8'h55}; c0_b = '{8'h22, 8'h44, 8'h66}; c0_m = '{4'h0, 4'h1, 4'h2};
    c1_a = '{8'h80, 8'h7F, 8'hFF}; c1_b = '{8'h01, 8'h01, 8'hFF}; c1_m = '{4'h3, 4'h0, 4'h4};
    cont_exp = '{8'h33, 8'h81, 8'hEF, 8'h80, 8'h44, 8'h00};

    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_mode = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_mode = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_en = 1;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk); #1;

    // 1. single op on req0
    base = log_id.size();
    issue(0, 8'h0A, 8'h02, 4'h0);
    wait_rsp(base + 1);
    if (log_id.size() > base) begin
      check("t1_latency", 32'(log_cyc[base] - acc_cyc), 32'd2);
      check("t1_id", 32'(log_id[base]), 32'd0);
      check("t1_data", 32'(log_data[base]), 32'h0C);
    end

    // 2. mode sweep on req1
    base = log_id.size();
    for (int m = 0; m < 16; m++) issue(1, 8'hF6, 8'h0A, 4'(m));
    wait_rsp(base + 16);
    for (int k = 0; k < 16 && base + k < log_id.size(); k++) begin
      check("t2_id", 32'(log_id[base+k]), 32'd1);
      check("t2_data", 32'(log_data[base+k]), 32'(sweep_exp[k]));
      if (k > 0) check("t2_interval", 32'(log_cyc[base+k] - log_cyc[base+k-1]), 32'd3);
    end

    // 3. continuous contention
    base = log_id.size();
    idx0 = 0; idx1 = 0;
    for (int c = 0; c < 60 && (idx0 < 3 || idx1 < 3); c++) begin
      req0_valid = (idx0 < 3);
      req1_valid = (idx1 < 3);
      if (idx0 < 3) begin req0_a = c0_a[idx0]; req0_b = c0_b[idx0]; req0_mode = c0_m[idx0]; end
      if (idx1 < 3) begin req1_a = c1_a[idx1]; req1_b = c1_b[idx1]; req1_mode = c1_m[idx1]; end
      @(negedge clk);
      h0 = req0_ready; h1 = req1_ready;
      @(posedge clk); #1;
      if (h0) idx0++;
      if (h1) idx1++;
    end
    req0_valid = 0; req1_valid = 0;
    check("t3_accepted", 32'(idx0 + idx1), 32'd6);
    wait_rsp(base + 6);
    for (int k = 0; k < 6 && base + k < log_id.size(); k++) begin
      check("t3_id", 32'(log_id[base+k]), 32'(k % 2));
      check("t3_data", 32'(log_data[base+k]), 32'(cont_exp[k]));
    end

    // 4. backpressure with req1 waiting
    base = log_id.size();
    rsp_ready = 0;
    issue(0, 8'hC8, 8'h64, 4'h1);
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h02; req1_mode = 4'h0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
      else begin @(posedge clk); #1; end
    end
    check("t4_rsp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_id", 32'(rsp_id), 32'd0);
      check("t4_hold_data", 32'(rsp_data), 32'h64);
      check("t4_hold_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(negedge clk);
    check("t4_complete_valid", 32'(rsp_valid), 32'd1);
    check("t4_no_accept_on_complete", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_accept_resumes", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_rsp(base + 2);
    if (log_id.size() >= base + 2) begin
      check("t4_first_data", 32'(log_data[base]), 32'h64);
      check("t4_second_id", 32'(log_id[base+1]), 32'd1);
      check("t4_second_data", 32'(log_data[base+1]), 32'h03);
    end

    // 5. reset during EXEC
    issue(0, 8'h12, 8'h34, 4'h0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    base = log_id.size();
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01; req0_mode = 4'h0;
    req1_valid = 1; req1_a = 8'h02; req1_b = 8'h02; req1_mode = 4'h0;
    @(negedge clk);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rsp_id", 32'(rsp_id), 32'd0);
    check("t5_rsp_data", 32'(rsp_data), 32'd0);
    check("t5_req0_first", 32'(req0_ready), 32'd1);
    check("t5_req1_waits", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 0;
    issue(1, 8'h02, 8'h02, 4'h0);
    wait_rsp(base + 2);
    if (log_id.size() >= base + 2) begin
      check("t5_first_id", 32'(log_id[base]), 32'd0);
      check("t5_first_data", 32'(log_data[base]), 32'h02);
      check("t5_second_data", 32'(log_data[base+1]), 32'h04);
    end

`ifdef ALU_RR_SEQUENCER_STATS_EN
    // 6. counters, saturating at 3 with a 2-bit width
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    base = log_id.size();
    for (int k = 0; k < 3; k++) issue(0, 8'(k), 8'h01, 4'h0);
    for (int k = 0; k < 2; k++) issue(1, 8'(k), 8'h02, 4'h0);
    wait_rsp(base + 5);
    @(negedge clk);
    check("t6_cnt0", 32'(op_cnt0), 32'd3);
    check("t6_cnt1", 32'(op_cnt1), 32'd2);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) issue(0, 8'h05, 8'h05, 4'h2);
    wait_rsp(base + 7);
    @(negedge clk);
    check("t6_cnt0_sat", 32'(op_cnt0), 32'd3);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
